// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern, glyph codes
// and the nibble-to-segment lookup function. Segment order is {a,b,c,d,e,f,g,dp}.
package seg_scan_driver_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] GLYPH_0 = 8'hFC;
  localparam logic [7:0] GLYPH_1 = 8'h60;
  localparam logic [7:0] GLYPH_2 = 8'hDA;
  localparam logic [7:0] GLYPH_3 = 8'hF2;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'hB6;
  localparam logic [7:0] GLYPH_6 = 8'hBE;
  localparam logic [7:0] GLYPH_7 = 8'hE0;
  localparam logic [7:0] GLYPH_8 = 8'hFE;
  localparam logic [7:0] GLYPH_9 = 8'hF6;
  localparam logic [7:0] GLYPH_A = 8'hEE;
  localparam logic [7:0] GLYPH_B = 8'h3E;
  localparam logic [7:0] GLYPH_C = 8'h9C;
  localparam logic [7:0] GLYPH_D = 8'h7A;
  localparam logic [7:0] GLYPH_E = 8'h9E;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  // Active-high segment pattern for one hex digit; dp bit is always 0 here.
  function automatic logic [7:0] seg_glyph(input logic [3:0] bcd);
    logic [7:0] g;
    case (bcd)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display data in from the time-formatting logic, pin drive out to the board.
interface seg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lzb_en;
  logic                    load;
  logic [7:0]              seg_data;
  logic [NUM_DIGITS-1:0]   seg_com;
  logic                    frame_tick;

  modport master (
    output digits, dp_in, digit_en, lzb_en, load,
    input  seg_data, seg_com, frame_tick
  );

  modport slave (
    input  digits, dp_in, digit_en, lzb_en, load,
    output seg_data, seg_com, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver_glyph_rom.sv
// Combinational nibble-to-glyph lookup for the currently scanned digit.
module seg_scan_driver_glyph_rom
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] glyph_c
);

  // Pure table lookup, no state.
  always_comb glyph_c = seg_glyph(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous shadow
// loading, dead-time blanking between slots and leading-zero blanking.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 10000,
  parameter int unsigned BLANK_CYCLES = 100,
  parameter int unsigned SEG_ACT_LOW  = 0,
  parameter int unsigned COM_ACT_LOW  = 1
) (
  input logic              clk,
  input logic              rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PCNT_W-1:0]     PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_POL   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] COM_POL   = (COM_ACT_LOW != 0) ?
                                                {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PCNT_W-1:0]          pcnt;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0][3:0] in_dig;
  logic [NUM_DIGITS-1:0][3:0] pend_dig;
  logic [NUM_DIGITS-1:0][3:0] act_dig;
  logic [NUM_DIGITS-1:0]      pend_dp;
  logic [NUM_DIGITS-1:0]      pend_en;
  logic [NUM_DIGITS-1:0]      act_dp;
  logic [NUM_DIGITS-1:0]      act_en;
  logic                       slot_end;
  logic                       frame_wrap;
  logic                       in_dead;
  logic                       zero_above;
  logic [NUM_DIGITS-1:0]      lzb_mask;
  logic [3:0]                 nib;
  logic [7:0]                 glyph;
  logic [7:0]                 seg_next;
  logic [NUM_DIGITS-1:0]      com_next;
  logic                       show;

  assign in_dig = bus.digits;

  // Slot and frame boundary decode.
  always_comb begin
    slot_end   = (pcnt == PCNT_LAST);
    frame_wrap = slot_end && (idx == IDX_LAST);
  end

  // Dead time at the start of every slot; absent entirely when BLANK_CYCLES is 0.
  if (BLANK_CYCLES == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (pcnt < PCNT_W'(BLANK_CYCLES));
  end

  // Prescaler and scan index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= frame_wrap ? '0 : idx + IDX_W'(1);
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  // Pending capture on load; active copy only at a frame boundary (a load on
  // the boundary cycle bypasses pending so it shows in the new frame).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_en  <= '1;
      act_dig  <= '0;
      act_dp   <= '0;
      act_en   <= '1;
    end else begin
      if (bus.load) begin
        pend_dig <= in_dig;
        pend_dp  <= bus.dp_in;
        pend_en  <= bus.digit_en;
      end
      if (frame_wrap) begin
        act_dig <= bus.load ? in_dig       : pend_dig;
        act_dp  <= bus.load ? bus.dp_in    : pend_dp;
        act_en  <= bus.load ? bus.digit_en : pend_en;
      end
    end
  end

  // Leading-zero mask: digit i>0 blanks when it and everything above it is zero or disabled.
  always_comb begin
    lzb_mask   = '0;
    zero_above = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (act_en[i] && (act_dig[i] != 4'h0)) zero_above = 1'b0;
      lzb_mask[i] = bus.lzb_en && zero_above;
    end
  end

  assign nib = act_dig[idx];

  seg_scan_driver_glyph_rom u_glyph_rom (
    .nibble  (nib),
    .glyph_c (glyph)
  );

  // Segment and common pattern for the current slot, before polarity.
  always_comb begin
    show     = !in_dead && act_en[idx];
    seg_next = (lzb_mask[idx] ? SEG_BLANK : glyph) | {7'b0, act_dp[idx]};
    com_next = NUM_DIGITS'(1) << idx;
  end

  // Pin registers; polarity is applied only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg_data   <= SEG_BLANK ^ SEG_POL;
      bus.seg_com    <= COM_POL;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= frame_wrap;
      if (show) begin
        bus.seg_data <= seg_next ^ SEG_POL;
        bus.seg_com  <= com_next ^ COM_POL;
      end else begin
        bus.seg_data <= SEG_BLANK ^ SEG_POL;
        bus.seg_com  <= COM_POL;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle reference pushes expected pin values each
// clock, a negedge checker pops them for both polarity variants, and directed
// frame checks cover scan order, LZB, shadow loading, enables and reset.
module tb_seg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] com;
    logic       tick;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(ND)) sif ();
  seg_scan_driver_if #(.NUM_DIGITS(ND)) sif2 ();

  assign sif2.digits   = sif.digits;
  assign sif2.dp_in    = sif.dp_in;
  assign sif2.digit_en = sif.digit_en;
  assign sif2.lzb_en   = sif.lzb_en;
  assign sif2.load     = sif.load;

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACT_LOW(0), .COM_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(sif)
  );

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACT_LOW(1), .COM_ACT_LOW(0)
  ) dut_pol (
    .clk(clk), .rst_n(rst_n), .bus(sif2)
  );

  logic [7:0] glyph_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state.
  int         m_pcnt, m_idx;
  logic [15:0] m_pdig, m_adig;
  logic [3:0]  m_pdp, m_pen, m_adp, m_aen;
  exp_t        sb_q[$];

  function automatic exp_t model_out();
    exp_t       e;
    logic       nonzero;
    logic [3:0] nb;
    logic [7:0] g;
    e.tick = (m_pcnt == SD - 1) && (m_idx == ND - 1);
    if (m_pcnt < BC || !m_aen[m_idx]) begin
      e.seg = 8'h00;
      e.com = 4'hF;
    end else begin
      nonzero = 1'b0;
      for (int j = m_idx; j < ND; j++) begin
        nb = m_adig[j*4 +: 4];
        if (m_aen[j] && nb != 4'h0) nonzero = 1'b1;
      end
      nb = m_adig[m_idx*4 +: 4];
      g = (m_idx > 0 && sif.lzb_en && !nonzero) ? 8'h00 : glyph_tbl[nb];
      e.seg = g | {7'b0, m_adp[m_idx]};
      e.com = ~(4'b0001 << m_idx);
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pcnt <= 0;
      m_idx  <= 0;
      m_pdig <= '0; m_pdp <= '0; m_pen <= 4'hF;
      m_adig <= '0; m_adp <= '0; m_aen <= 4'hF;
      sb_q.delete();
    end else begin
      sb_q.push_back(model_out());
      if (m_pcnt == SD - 1 && m_idx == ND - 1) begin
        m_adig <= sif.load ? sif.digits   : m_pdig;
        m_adp  <= sif.load ? sif.dp_in    : m_pdp;
        m_aen  <= sif.load ? sif.digit_en : m_pen;
      end
      if (sif.load) begin
        m_pdig <= sif.digits;
        m_pdp  <= sif.dp_in;
        m_pen  <= sif.digit_en;
      end
      if (m_pcnt == SD - 1) begin
        m_pcnt <= 0;
        m_idx  <= (m_idx == ND - 1) ? 0 : m_idx + 1;
      end else begin
        m_pcnt <= m_pcnt + 1;
      end
    end
  end

  // Scoreboard checker for both polarity variants.
  always @(negedge clk) begin : chk
    exp_t e;
    if (!rst_n || sb_q.size() == 0) e = '{seg: 8'h00, com: 4'hF, tick: 1'b0};
    else                            e = sb_q.pop_front();
    check_val("sb_seg",      sif.seg_data,    e.seg);
    check_val("sb_com",      sif.seg_com,     e.com);
    check_val("sb_tick",     sif.frame_tick,  e.tick);
    check_val("sb_pol_seg",  sif2.seg_data,   e.seg ^ 8'hFF);
    check_val("sb_pol_com",  sif2.seg_com,    e.com ^ 4'hF);
    check_val("sb_pol_tick", sif2.frame_tick, e.tick);
  end

  task automatic do_load(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] en);
    sif.digits   = dig;
    sif.dp_in    = dp;
    sif.digit_en = en;
    sif.load     = 1'b1;
    @(negedge clk);
    sif.load     = 1'b0;
  endtask

  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = sif.frame_tick;
    end
    check_val("tick_wait", 32'(seen), 32'd1);
  endtask

  // Called at the negedge where frame_tick is high; walks the whole frame.
  task automatic check_frame(input string tag, input logic [31:0] segs, input logic [3:0] en);
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < SD; k++) begin
        @(negedge clk);
        if (k < BC || !en[d]) begin
          check_val({tag, "_com_off"}, sif.seg_com, 4'hF);
          check_val({tag, "_seg_off"}, sif.seg_data, 8'h00);
        end else begin
          check_val({tag, "_com"}, sif.seg_com, ~(4'b0001 << d) & 4'hF);
          check_val({tag, "_seg"}, sif.seg_data, segs[d*8 +: 8]);
        end
      end
    end
    check_val({tag, "_next_tick"}, sif.frame_tick, 1'b1);
  endtask

  initial begin
    int cnt;
    sif.digits   = '0;
    sif.dp_in    = '0;
    sif.digit_en = 4'hF;
    sif.lzb_en   = 1'b0;
    sif.load     = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic scan order and glyphs.
    do_load(16'h1234, 4'h0, 4'hF);
    wait_tick();
    check_frame("scan", 32'h60DA_F266, 4'hF);

    // Leading-zero blanking on, then off.
    sif.lzb_en = 1'b1;
    do_load(16'h0070, 4'h0, 4'hF);
    wait_tick();
    check_frame("lzb_on", 32'h0000_E0FC, 4'hF);
    sif.lzb_en = 1'b0;
    check_frame("lzb_off", 32'hFCFC_E0FC, 4'hF);

    // Mid-frame load stays hidden until the next frame.
    repeat (3) @(negedge clk);
    do_load(16'h5555, 4'h0, 4'hF);
    repeat (23) @(negedge clk);
    check_val("shadow_old_com", sif.seg_com, 4'h7);
    check_val("shadow_old_seg", sif.seg_data, 8'hFC);
    wait_tick();
    check_frame("shadow_new", 32'hB6B6_B6B6, 4'hF);

    // Load on the boundary cycle itself shows in the new frame.
    repeat (31) @(negedge clk);
    do_load(16'h9999, 4'h0, 4'hF);
    check_val("bnd_tick", sif.frame_tick, 1'b1);
    check_frame("bnd_load", 32'hF6F6_F6F6, 4'hF);

    // Per-digit enable and decimal point.
    do_load(16'h1234, 4'b0001, 4'b0101);
    wait_tick();
    check_frame("en_dp", 32'h60DA_F267, 4'b0101);

    // Asynchronous reset in the middle of a live slot.
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_seg",     sif.seg_data,    8'h00);
    check_val("rst_com",     sif.seg_com,     4'hF);
    check_val("rst_tick",    sif.frame_tick,  1'b0);
    check_val("rst_pol_seg", sif2.seg_data,   8'hFF);
    check_val("rst_pol_com", sif2.seg_com,    4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 3) check_val("rst_idx0_com", sif.seg_com, 4'hE);
      if (sif.frame_tick) begin
        cnt = i;
        break;
      end
    end
    check_val("rst_first_tick", 32'(cnt), 32'd32);

    // Inverted polarity variant shows "8" as 01 with a high common.
    do_load(16'h8888, 4'h0, 4'hF);
    wait_tick();
    repeat (3) @(negedge clk);
    check_val("pol_seg8", sif2.seg_data, 8'h01);
    check_val("pol_com8", sif2.seg_com,  4'h1);
    repeat (6) @(negedge clk);
    check_val("pol_seg_blank", sif2.seg_data, 8'hFF);
    check_val("pol_com_blank", sif2.seg_com,  4'h0);

    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
